st7789_fill_rect: RTL and testbench
===================================

ST7789_FILL_RECT -- requirements
Module: st7789_fill_rect

Interface
REQ-001 Parameter H_RES, default 240, panel column count.
REQ-002 Parameter V_RES, default 320, panel row count.
REQ-003 CLK  in  1  sole clock; all logic on rising edge.
REQ-004 RESETN  in  1  reset, asynchronous, active-low.
REQ-005 CMD_X0, CMD_X1  in  9 each  inclusive column range.
REQ-006 CMD_Y0, CMD_Y1  in  9 each  inclusive row range.
REQ-007 COMPONENT_R, COMPONENT_G, COMPONENT_B  in  8 each  fill colour, RGB888.
REQ-008 CMD_VALID  in  1 / CMD_READY  out  1  rectangle command handshake.
REQ-009 DONE  out  1  one-cycle pulse when the final pixel byte is accepted.
REQ-010 ERR  out  1  one-cycle pulse when a command is rejected.
REQ-011 M_AXIS_TDATA  out  8 / TKEEP  out  1 / TUSER  out  1 / TVALID  out  1 / TLAST  out  1 / TREADY  in  1  byte stream to st7789_driver; TUSER=1 marks a command byte (DC low), TUSER=0 a data byte.

Function
REQ-012 CMD_READY shall be high only in IDLE; a command is taken on CMD_VALID&&CMD_READY, with all CMD_* and COMPONENT_* fields registered at that edge.
REQ-013 An accepted command with X0>X1, Y0>Y1, X1>=H_RES or Y1>=V_RES shall pulse ERR the next cycle, emit no bytes and stay in IDLE.
REQ-014 States: IDLE, CASET_C, CASET_D, RASET_C, RASET_D, RAMWR_C, PIX_HI, PIX_LO; each transition occurs only on a TVALID&&TREADY handshake.
REQ-015 Byte order: 0x2A(cmd); X0[15:8], X0[7:0], X1[15:8], X1[7:0]; 0x2B(cmd); Y0 hi, Y0 lo, Y1 hi, Y1 lo; 0x2C(cmd); then N pixels, each as high byte then low byte. Coordinates are zero-extended to 16 bits.
REQ-016 Pixel word = {R[7:3],G[7:2],B[7:3]}, computed once at accept.
REQ-017 N = (X1-X0+1)*(Y1-Y0+1), held in a 17-bit counter (max 76800); down-count one per PIX_LO handshake.
REQ-018 TLAST shall be 1 on X1 lo, on Y1 lo and on the final pixel's low byte; 0 on all other bytes. TKEEP shall be constant 1.
REQ-019 TVALID, TDATA, TUSER and TLAST shall be registered, with no combinational path from TREADY; they hold stable while TVALID&&!TREADY.
REQ-020 TVALID shall rise the cycle after accept and stay high until the final handshake; a stream of 11+2N bytes takes exactly 11+2N cycles when TREADY is held high.
REQ-021 DONE shall pulse in the cycle after the final handshake, TVALID shall drop in that same cycle, and CMD_READY shall be high that cycle.
REQ-022 CMD_VALID asserted while busy shall be ignored: no capture and no ERR.
REQ-023 A 1x1 rectangle gives N=1: exactly 13 bytes, with TLAST on byte 13.

Reset
REQ-024 RESETN low shall, asynchronously, set state to IDLE and clear all counters and captured fields.
REQ-025 While RESETN is low: TVALID=0, TDATA=0, TUSER=0, TLAST=0, TKEEP=1, DONE=0, ERR=0, CMD_READY=0.
REQ-026 CMD_READY=1 from the first clock edge after RESETN is released.
REQ-027 Reset asserted mid-stream aborts the stream immediately; no DONE is generated.

Structure
REQ-028 Shared package st7789_pkg shall hold the command constants CASET=0x2A, RASET=0x2B, RAMWR=0x2C, the state enum typedef and an RGB888-to-RGB565 function.
REQ-029 No sub-module; single flat module, with pixel packing via the package function.

Verification
REQ-030 Rect (0,0)-(1,0), R=G=B=0xFF, TREADY=1 -> 15 bytes: 2A,00,00,00,01,2B,00,00,00,00,2C,FF,FF,FF,FF; TUSER=1 on bytes 1,6,11; TLAST on bytes 5,10,15; DONE on cycle 16.
REQ-031 Rect (239,319)-(239,319), R=0xF8,G=0,B=0 -> params 00,EF,00,EF / 01,3F,01,3F; pixel F8,00; 13 bytes total.
REQ-032 X1=240 or X0=5,X1=4 -> ERR pulse, TVALID stays 0, CMD_READY stays high.
REQ-033 Full screen with random TREADY (~50%) -> 153611 bytes, TDATA stable during every stall, exactly one DONE.
REQ-034 RESETN low after byte 7 of a stream -> TVALID drops asynchronously; after release, a new 1x1 command streams a clean 13 bytes.
REQ-035 CMD_VALID pulsed during streaming -> no effect, no ERR, byte count unchanged.

Source files
------------

// File: rtl/st7789_pkg.sv
// ST7789 command constants, fill-engine state encoding
// and RGB888 to RGB565 packing shared by the fill path.
package st7789_pkg;

   localparam logic [7:0] CASET = 8'h2A;
   localparam logic [7:0] RASET = 8'h2B;
   localparam logic [7:0] RAMWR = 8'h2C;

   typedef enum logic [2:0] {
      IDLE,
      CASET_C,
      CASET_D,
      RASET_C,
      RASET_D,
      RAMWR_C,
      PIX_HI,
      PIX_LO
   } state_t;

   function automatic logic [15:0] rgb565(
      input logic [7:0] r,
      input logic [7:0] g,
      input logic [7:0] b
   );
      return {r[7:3], g[7:2], b[7:3]};
   endfunction

endpackage

// File: rtl/st7789_fill_rect.sv
// Turns one rectangle fill command into the ST7789 byte stream:
// CASET, RASET, RAMWR, then N copies of the packed RGB565 colour.
module st7789_fill_rect
   import st7789_pkg::*;
#(
   parameter int H_RES = 240,
   parameter int V_RES = 320
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic [8:0] CMD_X0,
   input  logic [8:0] CMD_X1,
   input  logic [8:0] CMD_Y0,
   input  logic [8:0] CMD_Y1,
   input  logic [7:0] COMPONENT_R,
   input  logic [7:0] COMPONENT_G,
   input  logic [7:0] COMPONENT_B,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   output logic       DONE,
   output logic       ERR,
   output logic [7:0] M_AXIS_TDATA,
   output logic       M_AXIS_TKEEP,
   output logic       M_AXIS_TUSER,
   output logic       M_AXIS_TVALID,
   output logic       M_AXIS_TLAST,
   input  logic       M_AXIS_TREADY
);

   localparam logic [9:0] H_LIM = 10'(H_RES);
   localparam logic [9:0] V_LIM = 10'(V_RES);

   state_t      state, state_n;
   logic [1:0]  idx, idx_n;
   logic [16:0] cnt, cnt_n;
   logic [8:0]  x0, x1, y0, y1;
   logic [8:0]  x0_n, x1_n, y0_n, y1_n;
   logic [15:0] pix, pix_n;
   logic        rdy;
   logic        tvalid, tvalid_n;
   logic [7:0]  tdata, tdata_n;
   logic        tuser, tuser_n;
   logic        tlast, tlast_n;
   logic        done, done_n;
   logic        err, err_n;

   logic        accept, hs, bad, ob_load;
   logic [16:0] w_in, h_in, n_in;

   function automatic logic [7:0] coord_byte(
      input logic [8:0] a,
      input logic [8:0] b,
      input logic [1:0] i
   );
      case (i)
         2'd0:    return {7'd0, a[8]};
         2'd1:    return a[7:0];
         2'd2:    return {7'd0, b[8]};
         default: return b[7:0];
      endcase
   endfunction

   assign CMD_READY     = rdy && (state == IDLE);
   assign accept        = CMD_VALID && CMD_READY;
   assign hs            = tvalid && M_AXIS_TREADY;
   assign M_AXIS_TVALID = tvalid;
   assign M_AXIS_TDATA  = tdata;
   assign M_AXIS_TUSER  = tuser;
   assign M_AXIS_TLAST  = tlast;
   assign M_AXIS_TKEEP  = 1'b1;
   assign DONE          = done;
   assign ERR           = err;

   assign bad = (CMD_X0 > CMD_X1) || (CMD_Y0 > CMD_Y1)
             || ({1'b0, CMD_X1} >= H_LIM)
             || ({1'b0, CMD_Y1} >= V_LIM);

   // Only meaningful for accepted, in-range commands
   assign w_in = {8'd0, CMD_X1 - CMD_X0} + 17'd1;
   assign h_in = {8'd0, CMD_Y1 - CMD_Y0} + 17'd1;
   assign n_in = w_in * h_in;

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      cnt_n    = cnt;
      x0_n     = x0;
      x1_n     = x1;
      y0_n     = y0;
      y1_n     = y1;
      pix_n    = pix;
      tvalid_n = tvalid;
      tdata_n  = tdata;
      tuser_n  = tuser;
      tlast_n  = tlast;
      done_n   = 1'b0;
      err_n    = 1'b0;
      ob_load  = 1'b0;

      if (accept) begin
         x0_n  = CMD_X0;
         x1_n  = CMD_X1;
         y0_n  = CMD_Y0;
         y1_n  = CMD_Y1;
         pix_n = rgb565(COMPONENT_R, COMPONENT_G, COMPONENT_B);
         cnt_n = n_in;
         if (bad) begin
            err_n = 1'b1;
         end else begin
            state_n  = CASET_C;
            idx_n    = 2'd0;
            tvalid_n = 1'b1;
            tdata_n  = CASET;
            tuser_n  = 1'b1;
            tlast_n  = 1'b0;
         end
      end else if (hs) begin
         ob_load = 1'b1;
         case (state)
            CASET_C: begin
               state_n = CASET_D;
               idx_n   = 2'd0;
            end
            CASET_D: begin
               if (idx == 2'd3) state_n = RASET_C;
               else             idx_n   = idx + 2'd1;
            end
            RASET_C: begin
               state_n = RASET_D;
               idx_n   = 2'd0;
            end
            RASET_D: begin
               if (idx == 2'd3) state_n = RAMWR_C;
               else             idx_n   = idx + 2'd1;
            end
            RAMWR_C: state_n = PIX_HI;
            PIX_HI:  state_n = PIX_LO;
            PIX_LO: begin
               cnt_n = cnt - 17'd1;
               if (cnt == 17'd1) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  state_n = PIX_HI;
               end
            end
            default: state_n = IDLE;
         endcase
      end

      // Next byte is chosen from the state being entered
      if (ob_load) begin
         tvalid_n = 1'b1;
         tdata_n  = 8'h00;
         tuser_n  = 1'b0;
         tlast_n  = 1'b0;
         case (state_n)
            CASET_C: begin
               tdata_n = CASET;
               tuser_n = 1'b1;
            end
            CASET_D: begin
               tdata_n = coord_byte(x0, x1, idx_n);
               tlast_n = (idx_n == 2'd3);
            end
            RASET_C: begin
               tdata_n = RASET;
               tuser_n = 1'b1;
            end
            RASET_D: begin
               tdata_n = coord_byte(y0, y1, idx_n);
               tlast_n = (idx_n == 2'd3);
            end
            RAMWR_C: begin
               tdata_n = RAMWR;
               tuser_n = 1'b1;
            end
            PIX_HI: tdata_n = pix[15:8];
            PIX_LO: begin
               tdata_n = pix[7:0];
               tlast_n = (cnt_n == 17'd1);
            end
            default: tvalid_n = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state  <= IDLE;
         idx    <= 2'd0;
         cnt    <= 17'd0;
         x0     <= 9'd0;
         x1     <= 9'd0;
         y0     <= 9'd0;
         y1     <= 9'd0;
         pix    <= 16'd0;
         rdy    <= 1'b0;
         tvalid <= 1'b0;
         tdata  <= 8'd0;
         tuser  <= 1'b0;
         tlast  <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         cnt    <= cnt_n;
         x0     <= x0_n;
         x1     <= x1_n;
         y0     <= y0_n;
         y1     <= y1_n;
         pix    <= pix_n;
         rdy    <= 1'b1;
         tvalid <= tvalid_n;
         tdata  <= tdata_n;
         tuser  <= tuser_n;
         tlast  <= tlast_n;
         done   <= done_n;
         err    <= err_n;
      end
   end

endmodule

// File: tb/tb_st7789_fill_rect.sv
// Directed bench for st7789_fill_rect: byte scoreboard, stall
// stability, done/err pulses, timing and mid-stream reset.
module tb_st7789_fill_rect;

   logic       CLK = 1'b0;
   logic       RESETN = 1'b0;
   logic [8:0] CMD_X0 = '0, CMD_X1 = '0, CMD_Y0 = '0, CMD_Y1 = '0;
   logic [7:0] COMPONENT_R = '0, COMPONENT_G = '0, COMPONENT_B = '0;
   logic       CMD_VALID = 1'b0;
   logic       CMD_READY, DONE, ERR;
   logic [7:0] M_AXIS_TDATA;
   logic       M_AXIS_TKEEP, M_AXIS_TUSER, M_AXIS_TVALID, M_AXIS_TLAST;
   logic       M_AXIS_TREADY = 1'b0;

   st7789_fill_rect #(.H_RES(240), .V_RES(320)) dut (
      .CLK(CLK), .RESETN(RESETN),
      .CMD_X0(CMD_X0), .CMD_X1(CMD_X1),
      .CMD_Y0(CMD_Y0), .CMD_Y1(CMD_Y1),
      .COMPONENT_R(COMPONENT_R), .COMPONENT_G(COMPONENT_G),
      .COMPONENT_B(COMPONENT_B),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .DONE(DONE), .ERR(ERR),
      .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
      .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TVALID(M_AXIS_TVALID),
      .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int err_cnt = 0;
   int bytes = 0;
   int acc_cyc = 0;
   logic rand_rdy = 1'b0;
   logic rdy_fix = 1'b1;
   logic stalled = 1'b0;
   logic [9:0] held = '0;
   logic [9:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   always @(posedge CLK) begin
      #1;
      if (rand_rdy) M_AXIS_TREADY = 1'($urandom_range(0, 1));
      else          M_AXIS_TREADY = rdy_fix;
   end

   // Byte monitor: a byte is consumed on the posedge after a negedge
   // where TVALID and TREADY are both high.
   always @(negedge CLK) begin
      logic [10:0] exp;
      if (RESETN) begin
         if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_tvalid_low", 32'(M_AXIS_TVALID), 32'd0);
            chk("done_cmd_ready", 32'(CMD_READY), 32'd1);
         end
         if (ERR) err_cnt++;
         if (M_AXIS_TVALID) begin
            if (stalled)
               chk("stall_hold",
                   32'({M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA}),
                   32'(held));
            if (M_AXIS_TREADY) begin
               bytes++;
               exp = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 11'h400;
               chk("stream_byte",
                   32'({1'b0, M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA}),
                   32'(exp));
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA};
            end
         end else begin
            stalled = 1'b0;
         end
      end else begin
         stalled = 1'b0;
      end
   end

   task automatic push_rect(input logic [8:0] x0, y0, x1, y1,
                            input logic [7:0] r, g, b);
      logic [15:0] p;
      int n;
      p = {r[7:3], g[7:2], b[7:3]};
      n = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
      sb.push_back({2'b10, 8'h2A});
      sb.push_back({2'b00, 7'd0, x0[8]});
      sb.push_back({2'b00, x0[7:0]});
      sb.push_back({2'b00, 7'd0, x1[8]});
      sb.push_back({2'b01, x1[7:0]});
      sb.push_back({2'b10, 8'h2B});
      sb.push_back({2'b00, 7'd0, y0[8]});
      sb.push_back({2'b00, y0[7:0]});
      sb.push_back({2'b00, 7'd0, y1[8]});
      sb.push_back({2'b01, y1[7:0]});
      sb.push_back({2'b10, 8'h2C});
      for (int i = 0; i < n; i++) begin
         sb.push_back({2'b00, p[15:8]});
         sb.push_back({1'b0, i == n - 1, p[7:0]});
      end
   endtask

   task automatic send(input logic [8:0] x0, y0, x1, y1,
                       input logic [7:0] r, g, b);
      int t = 0;
      while (!CMD_READY && t < 1000) begin
         @(posedge CLK);
         #1;
         t++;
      end
      chk("cmd_ready_wait", 32'(CMD_READY), 32'd1);
      CMD_X0 = x0; CMD_Y0 = y0; CMD_X1 = x1; CMD_Y1 = y1;
      COMPONENT_R = r; COMPONENT_G = g; COMPONENT_B = b;
      CMD_VALID = 1'b1;
      @(posedge CLK);
      #1;
      acc_cyc = cyc;
      CMD_VALID = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      int t = 0;
      while (done_cnt == d0 && t < budget) begin
         @(negedge CLK);
         #1;
         t++;
      end
      chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
      repeat (3) @(posedge CLK);
      #1;
      chk("done_single", 32'(done_cnt), 32'(d0 + 1));
      chk("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   logic [9:0] t1 [15] = '{10'h22A, 10'h000, 10'h000, 10'h000, 10'h101,
                           10'h22B, 10'h000, 10'h000, 10'h000, 10'h100,
                           10'h22C, 10'h0FF, 10'h0FF, 10'h0FF, 10'h1FF};
   logic [9:0] t2 [13] = '{10'h22A, 10'h000, 10'h0EF, 10'h000, 10'h1EF,
                           10'h22B, 10'h001, 10'h03F, 10'h001, 10'h13F,
                           10'h22C, 10'h0F8, 10'h100};

   initial begin
      int b0, e0, d0, t;

      // Reset state
      #23;
      chk("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
      chk("rst_tdata", 32'(M_AXIS_TDATA), 32'd0);
      chk("rst_tuser", 32'(M_AXIS_TUSER), 32'd0);
      chk("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
      chk("rst_tkeep", 32'(M_AXIS_TKEEP), 32'd1);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      chk("rst_ready", 32'(CMD_READY), 32'd0);
      @(negedge CLK);
      RESETN = 1'b1;
      @(posedge CLK);
      #1;
      chk("ready_after_rst", 32'(CMD_READY), 32'd1);

      // 2x1 white
      foreach (t1[i]) sb.push_back(t1[i]);
      b0 = bytes;
      send(9'd0, 9'd0, 9'd1, 9'd0, 8'hFF, 8'hFF, 8'hFF);
      chk("tvalid_after_accept", 32'(M_AXIS_TVALID), 32'd1);
      chk("ready_busy", 32'(CMD_READY), 32'd0);
      wait_done(100);
      chk("t1_latency", 32'(done_cyc - acc_cyc), 32'd15);
      chk("t1_bytes", 32'(bytes - b0), 32'd15);

      // 1x1 bottom-right red
      foreach (t2[i]) sb.push_back(t2[i]);
      b0 = bytes;
      send(9'd239, 9'd319, 9'd239, 9'd319, 8'hF8, 8'h00, 8'h00);
      wait_done(100);
      chk("t2_latency", 32'(done_cyc - acc_cyc), 32'd13);
      chk("t2_bytes", 32'(bytes - b0), 32'd13);

      // 3x2 mixed colour
      push_rect(9'd3, 9'd2, 9'd5, 9'd3, 8'h12, 8'h34, 8'h56);
      send(9'd3, 9'd2, 9'd5, 9'd3, 8'h12, 8'h34, 8'h56);
      wait_done(200);
      chk("t3_latency", 32'(done_cyc - acc_cyc), 32'd23);

      // Rejected commands
      e0 = err_cnt;
      b0 = bytes;
      send(9'd0, 9'd0, 9'd240, 9'd0, 8'h11, 8'h22, 8'h33);
      chk("err_x1_pulse", 32'(ERR), 32'd1);
      chk("err_x1_tvalid", 32'(M_AXIS_TVALID), 32'd0);
      chk("err_x1_ready", 32'(CMD_READY), 32'd1);
      @(posedge CLK);
      #1;
      chk("err_one_cycle", 32'(ERR), 32'd0);
      send(9'd5, 9'd0, 9'd4, 9'd0, 8'h11, 8'h22, 8'h33);
      chk("err_order_pulse", 32'(ERR), 32'd1);
      chk("err_order_tvalid", 32'(M_AXIS_TVALID), 32'd0);
      send(9'd0, 9'd10, 9'd0, 9'd320, 8'h11, 8'h22, 8'h33);
      chk("err_y1_pulse", 32'(ERR), 32'd1);
      repeat (4) @(posedge CLK);
      #1;
      chk("err_no_bytes", 32'(bytes - b0), 32'd0);
      chk("err_count", 32'(err_cnt - e0), 32'd3);

      // Random stalls with ignored commands mid-stream
      rand_rdy = 1'b1;
      e0 = err_cnt;
      b0 = bytes;
      push_rect(9'd0, 9'd0, 9'd239, 9'd19, 8'hA5, 8'h5A, 8'hC3);
      send(9'd0, 9'd0, 9'd239, 9'd19, 8'hA5, 8'h5A, 8'hC3);
      for (int k = 0; k < 4; k++) begin
         repeat (40) @(posedge CLK);
         #1;
         CMD_X0 = 9'd1; CMD_X1 = (k[0]) ? 9'd2 : 9'd300;
         CMD_Y0 = 9'd1; CMD_Y1 = 9'd2;
         COMPONENT_R = 8'h00;
         CMD_VALID = 1'b1;
         @(posedge CLK);
         #1;
         CMD_VALID = 1'b0;
      end
      wait_done(40000);
      chk("rand_bytes", 32'(bytes - b0), 32'd9611);
      chk("rand_no_err", 32'(err_cnt - e0), 32'd0);
      rand_rdy = 1'b0;
      @(posedge CLK);
      #1;

      // Reset during a stream, then a clean 1x1
      push_rect(9'd7, 9'd7, 9'd7, 9'd7, 8'h80, 8'h40, 8'h20);
      b0 = bytes;
      send(9'd7, 9'd7, 9'd7, 9'd7, 8'h80, 8'h40, 8'h20);
      t = 0;
      while (bytes < b0 + 7 && t < 100) begin
         @(negedge CLK);
         #1;
         t++;
      end
      chk("mid_bytes", 32'(bytes - b0), 32'd7);
      @(posedge CLK);
      #2;
      d0 = done_cnt;
      RESETN = 1'b0;
      #1;
      chk("mid_rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
      chk("mid_rst_ready", 32'(CMD_READY), 32'd0);
      sb.delete();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESETN = 1'b1;
      @(posedge CLK);
      #1;
      chk("mid_no_done", 32'(done_cnt), 32'(d0));
      b0 = bytes;
      push_rect(9'd100, 9'd50, 9'd100, 9'd50, 8'h0F, 8'hF0, 8'h3C);
      send(9'd100, 9'd50, 9'd100, 9'd50, 8'h0F, 8'hF0, 8'h3C);
      wait_done(100);
      chk("post_rst_bytes", 32'(bytes - b0), 32'd13);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
